multi_key_debouncer: RTL
========================

Name: multi_key_debouncer

Overview:
- Parametrised N-channel successor to the single-key debouncer.
- Per channel: 2-FF synchroniser, configurable key polarity, a debounce filter on both press and release, and a registered level output.
- Emits one-cycle press and release pulses, plus optional auto-repeat pulses while a key is held (e.g. hold-to-shift in the game controller).
- Sits between board push-buttons and the game control FSM.

Parameters:
- CHANNELS, 4: number of independent key channels (>=1).
- ACTIVE_LOW, 1: 1 means key_in=0 is pressed; 0 means key_in=1 is pressed.
- DEBOUNCE_CYCLES, 250000: consecutive stable synchronised samples required to accept a press or a release (>=2).
- REPEAT_DELAY, 12500000: cycles from key_press to the first key_repeat (>=1).
- REPEAT_PERIOD, 5000000: cycles between subsequent key_repeat pulses (>=1).
- Counter widths: derived with $clog2 of the largest constant, +1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low; one clock, reset sampled on rising clk only.
- key_in  in  CHANNELS  raw asynchronous key inputs.
- repeat_en  in  CHANNELS  per-channel auto-repeat enable (synchronous).
- key_level  out  CHANNELS  debounced state, 1 = pressed.
- key_press  out  CHANNELS  1-cycle pulse on accepted press.
- key_release  out  CHANNELS  1-cycle pulse on accepted release.
- key_repeat  out  CHANNELS  1-cycle auto-repeat pulse.
- any_press  out  1  registered OR of the key_press inputs (same cycle as key_press).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All outputs 0; all FSMs IDLE; all counters 0.
  - Synchroniser FFs load the released level (1 if ACTIVE_LOW, else 0), so no false press after reset.
- Synchroniser: p[i] = polarity-normalised output of the second sync FF; 1 = pressed.
- Per-channel FSM with states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT:
  - IDLE: key_level=0, db_cnt=0. If p=1, go to PRESS_WAIT with db_cnt=1.
  - PRESS_WAIT:
    - If p=0, go to IDLE with db_cnt=0 (bounce rejected, no pulse).
    - Else if db_cnt==DEBOUNCE_CYCLES-1, go to HELD: key_level<=1, key_press<=1 for 1 cycle, rep_cnt=0.
    - Else db_cnt++.
  - HELD:
    - If p=0, go to RELEASE_WAIT with db_cnt=1. rep_cnt holds its value (frozen).
    - Else rep_cnt advances (see Repeat below).
  - RELEASE_WAIT:
    - If p=1, return to HELD with db_cnt=0. No pulse; rep_cnt resumes from its frozen value.
    - Else if db_cnt==DEBOUNCE_CYCLES-1, go to IDLE: key_level<=0, key_release<=1 for 1 cycle, rep_cnt=0.
    - Else db_cnt++.
- Latency: a clean press that is stable from edge k produces key_press high in the cycle after edge k+DEBOUNCE_CYCLES+2 (2 sync + DEBOUNCE_CYCLES samples). Release latency is identical.
- Repeat (HELD only, repeat_en[i]=1):
  - rep_cnt counts cycles since the press pulse.
  - The first key_repeat fires when rep_cnt reaches REPEAT_DELAY; rep_cnt then reloads to REPEAT_DELAY-REPEAT_PERIOD.
  - Net effect: a pulse every REPEAT_PERIOD cycles thereafter, with no drift.
- repeat_en[i]=0:
  - rep_cnt is held at 0 and key_repeat=0.
  - When repeat_en rises mid-hold, the full REPEAT_DELAY restarts.
- Pulse exclusivity:
  - key_press and key_release are never high together on one channel.
  - key_repeat is never coincident with key_press.
- Channel independence: simultaneous events on different channels are all reported in the same cycle; any_press=1 if any channel presses.
- Reset asserted mid-operation (any state): next cycle everything returns to reset values and no release pulse is emitted.
- Counter saturation: db_cnt never exceeds DEBOUNCE_CYCLES-1; rep_cnt never exceeds REPEAT_DELAY. No wrap-around is possible.

Test Plan:
(Sim params: CHANNELS=2, ACTIVE_LOW=1, DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5.)
- Clean press: hold key_in[0]=0 from edge 10 → key_press[0] one cycle at edge 20 (10+8+2), key_level[0]=1 from edge 20, any_press=1 at edge 20. Then key_in[0]=1 at edge 40 → key_release[0] at edge 50, key_level[0]=0.
- Bounce rejection: key_in[0] toggles every 3 cycles for 40 cycles → no pulses, key_level stays 0. A 5-cycle glitch during HELD → no key_release, key_level stays 1.
- Auto-repeat: repeat_en=1, hold 60 cycles after key_press at edge T → key_repeat at T+20, T+25, T+30, ...; none after release is accepted. With repeat_en=0 → no key_repeat.
- repeat_en mid-hold: raise repeat_en at T+12 → first key_repeat at T+32.
- Multi-channel/simultaneous: both channels pressed on the same edge → key_press=2'b11 in the same cycle, any_press=1 once. Then release ch1 only → key_release=2'b10.
- Reset: assert rst_n=0 for 1 cycle while in HELD → all outputs 0 next edge, no key_release. If the key is still held afterwards, key_press fires again DEBOUNCE_CYCLES+2 cycles later. Polarity check with ACTIVE_LOW=0 mirrors the clean-press case.

Source files
------------

// File: rtl/multi_key_debouncer.sv
// N-channel key debouncer with press/release pulses and auto-repeat.
// Each channel: 2-FF synchroniser, polarity normalisation, 4-state filter FSM.
module multi_key_debouncer #(
    parameter int CHANNELS        = 4,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int REPEAT_DELAY    = 12500000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] key_in,
    input  logic [CHANNELS-1:0] repeat_en,
    output logic [CHANNELS-1:0] key_level,
    output logic [CHANNELS-1:0] key_press,
    output logic [CHANNELS-1:0] key_release,
    output logic [CHANNELS-1:0] key_repeat,
    output logic                any_press
);

    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int REP_W = $clog2(REPEAT_DELAY) + 1;

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_TOP  = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] REP_LOAD = REP_W'((REPEAT_PERIOD >= REPEAT_DELAY) ?
                                                   0 : REPEAT_DELAY - REPEAT_PERIOD);
    // Raw input level meaning "released"; also the sync reset value.
    localparam logic REL_LVL = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    logic [CHANNELS-1:0] press_d;
    logic                any_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t           state_q, state_d;
        logic [1:0]       sync_q;
        logic [DB_W-1:0]  db_q, db_d;
        logic [REP_W-1:0] rep_q, rep_d;
        logic             lvl_q, lvl_d;
        logic             prs_q, prs_d;
        logic             rel_q, rel_d;
        logic             rpt_q, rpt_d;
        logic             p;

        assign p = sync_q[1] ^ REL_LVL;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                sync_q  <= {2{REL_LVL}};
                state_q <= IDLE;
                db_q    <= '0;
                rep_q   <= '0;
                lvl_q   <= 1'b0;
                prs_q   <= 1'b0;
                rel_q   <= 1'b0;
                rpt_q   <= 1'b0;
            end else begin
                sync_q  <= {sync_q[0], key_in[i]};
                state_q <= state_d;
                db_q    <= db_d;
                rep_q   <= rep_d;
                lvl_q   <= lvl_d;
                prs_q   <= prs_d;
                rel_q   <= rel_d;
                rpt_q   <= rpt_d;
            end
        end

        always_comb begin
            state_d = state_q;
            db_d    = db_q;
            rep_d   = rep_q;
            lvl_d   = lvl_q;
            prs_d   = 1'b0;
            rel_d   = 1'b0;
            rpt_d   = 1'b0;
            unique case (state_q)
                IDLE: begin
                    db_d = '0;
                    if (p) begin
                        state_d = PRESS_WAIT;
                        db_d    = DB_W'(1);
                    end
                end
                PRESS_WAIT: begin
                    if (!p) begin
                        state_d = IDLE;
                        db_d    = '0;
                    end else if (db_q == DB_LAST) begin
                        state_d = HELD;
                        db_d    = '0;
                        lvl_d   = 1'b1;
                        prs_d   = 1'b1;
                        rep_d   = '0;
                    end else begin
                        db_d = db_q + DB_W'(1);
                    end
                end
                HELD: begin
                    if (!p) begin
                        state_d = RELEASE_WAIT;
                        db_d    = DB_W'(1);
                    end else if ((rep_q + REP_W'(1)) == REP_TOP) begin
                        // Reload keeps later pulses on an exact period grid.
                        rpt_d = 1'b1;
                        rep_d = REP_LOAD;
                    end else begin
                        rep_d = rep_q + REP_W'(1);
                    end
                end
                RELEASE_WAIT: begin
                    if (p) begin
                        state_d = HELD;
                        db_d    = '0;
                    end else if (db_q == DB_LAST) begin
                        state_d = IDLE;
                        db_d    = '0;
                        lvl_d   = 1'b0;
                        rel_d   = 1'b1;
                        rep_d   = '0;
                    end else begin
                        db_d = db_q + DB_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
            if (!repeat_en[i]) begin
                rep_d = '0;
                rpt_d = 1'b0;
            end
        end

        assign press_d[i]     = prs_d;
        assign key_level[i]   = lvl_q;
        assign key_press[i]   = prs_q;
        assign key_release[i] = rel_q;
        assign key_repeat[i]  = rpt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            any_q <= 1'b0;
        end else begin
            any_q <= |press_d;
        end
    end

    assign any_press = any_q;

endmodule
